// File: rtl/div_fx.sv
// div_fx: signed fixed-point restoring divider with selectable rounding, inexact flag and valid/ready handshake
module div_fx #(
    parameter int WIDTH = 32,
    parameter int FBITS = 16,
    parameter int STEPS = 1,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       rmode,
    input  logic [TAGW-1:0]  tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] val,
    output logic [TAGW-1:0]  tag_out,
    output logic             dbz,
    output logic             ovf,
    output logic             inexact
);
    localparam int DW = WIDTH + FBITS;
    localparam int N  = DW / STEPS;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] SMALLEST = {1'b1, {(WIDTH-1){1'b0}}};
    if (DW % STEPS != 0) begin : g_steps_chk
        $error("div_fx: WIDTH+FBITS must be a multiple of STEPS");
    end
    if (FBITS < 0 || FBITS >= WIDTH - 1) begin : g_fbits_chk
        $error("div_fx: FBITS must satisfy 0 <= FBITS < WIDTH-1");
    end
    typedef enum logic [2:0] {IDLE, INIT, CALC, ROUND, SIGN, DONE} state_t;
    state_t state_q;
    logic [WIDTH-2:0] au_q, bu_q, mag_q, a_abs, b_abs;
    logic [WIDTH-1:0] acc_q, acc_d, quo_q, quo_d, sh, rnd_d, val_q;
    logic [DW-1:0]    dvd_q, dvd_d;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       rmode_q;
    logic [TAGW-1:0]  tag_q, tag_out_q;
    logic sig_q, ovfp_q, ovfp_d, inex_q, dbz_q, ovf_q, inexact_q, guard, sticky, inc;
    always_comb begin
        a_abs  = a[WIDTH-1] ? ~a[WIDTH-2:0] + (WIDTH-1)'(1) : a[WIDTH-2:0];
        b_abs  = b[WIDTH-1] ? ~b[WIDTH-2:0] + (WIDTH-1)'(1) : b[WIDTH-2:0];
        acc_d  = acc_q;
        quo_d  = quo_q;
        dvd_d  = dvd_q;
        ovfp_d = ovfp_q;
        sh     = '0;
        // quotient bits pushed out of the top of quo are the integer overflow bits
        for (int s = 0; s < STEPS; s++) begin
            sh     = {acc_d[WIDTH-2:0], dvd_d[DW-1]};
            ovfp_d = ovfp_d | quo_d[WIDTH-1];
            quo_d  = {quo_d[WIDTH-2:0], sh >= {1'b0, bu_q}};
            acc_d  = sh >= {1'b0, bu_q} ? sh - {1'b0, bu_q} : sh;
            dvd_d  = dvd_d << 1;
        end
        guard  = quo_q[0];
        sticky = |acc_q;
        inc    = rmode_q == 2'd0 ? 1'b0 :
                 rmode_q == 2'd1 ? guard & (quo_q[1] | sticky) :
                 rmode_q == 2'd2 ? guard : sig_q & (guard | sticky);
        rnd_d  = {1'b0, quo_q[WIDTH-1:1]} + WIDTH'(inc);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            val_q     <= '0;
            tag_out_q <= '0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    tag_q   <= tag_in;
                    rmode_q <= rmode;
                    au_q    <= a_abs;
                    bu_q    <= b_abs;
                    sig_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                    if (b == '0 || a == SMALLEST || b == SMALLEST) begin
                        state_q   <= DONE;
                        val_q     <= '0;
                        tag_out_q <= tag_in;
                        dbz_q     <= b == '0;
                        ovf_q     <= b != '0;
                        inexact_q <= 1'b0;
                    end else begin
                        state_q <= INIT;
                    end
                end
                INIT: begin
                    acc_q   <= '0;
                    quo_q   <= '0;
                    dvd_q   <= {au_q, {(FBITS+1){1'b0}}};
                    cnt_q   <= '0;
                    ovfp_q  <= 1'b0;
                    state_q <= CALC;
                end
                CALC: begin
                    acc_q  <= acc_d;
                    quo_q  <= quo_d;
                    dvd_q  <= dvd_d;
                    ovfp_q <= ovfp_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N-1)) state_q <= ROUND;
                end
                ROUND: begin
                    mag_q   <= rnd_d[WIDTH-2:0];
                    ovfp_q  <= ovfp_q | rnd_d[WIDTH-1];
                    inex_q  <= guard | sticky;
                    state_q <= SIGN;
                end
                SIGN: begin
                    val_q     <= ovfp_q ? '0 : sig_q ? -{1'b0, mag_q} : {1'b0, mag_q};
                    ovf_q     <= ovfp_q;
                    dbz_q     <= 1'b0;
                    inexact_q <= ~ovfp_q & inex_q;
                    tag_out_q <= tag_q;
                    state_q   <= DONE;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign val       = val_q;
    assign tag_out   = tag_out_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;
    assign inexact   = inexact_q;
endmodule
